// File: rtl/axi_header_pkg.sv
// Shared types and helpers for the AXI header slave and its skid buffer.
// Defines the buffer occupancy states and a byte-count to keep-mask helper.
package axi_header_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int MAX_KEEP_BYTES = 64;

  // cnt is "bytes minus one"; a shift by the full width yields 0, so the
  // subtraction still produces an all-ones mask for the widest count.
  function automatic logic [MAX_KEEP_BYTES-1:0] keep_from_cnt(input int unsigned cnt);
    logic [MAX_KEEP_BYTES-1:0] one;
    one = MAX_KEEP_BYTES'(1);
    return (one << (cnt + 1)) - one;
  endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
// Latency 1 cycle; s_ready is registered and drops the cycle after FULL is entered.
// Backpressure: holds m_data stable while m_valid && !m_ready, order preserved.
module axi_skid_buffer
  import axi_header_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  buf_state_t       state, state_nxt;
  logic             accept, drain;
  logic             load_out, load_skid, out_from_skid;
  logic [WIDTH-1:0] out_q, skid_q;
  logic             ready_q, valid_q;

  assign accept  = s_valid && ready_q;
  assign drain   = valid_q && m_ready;
  assign s_ready = ready_q;
  assign m_valid = valid_q;
  assign m_data  = out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !drain)      state_nxt = FULL;
        else if (!accept && drain) state_nxt = EMPTY;
      end
      FULL: if (drain) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // FULL never sees an accept because s_ready is already low there.
  always_comb begin
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    unique case (state)
      EMPTY: load_out = accept;
      ONE: begin
        if (accept && drain) load_out  = 1'b1;
        else if (accept)     load_skid = 1'b1;
      end
      FULL: begin
        load_out      = drain;
        out_from_skid = drain;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : s_data;
      if (load_skid) skid_q <= s_data;
      ready_q <= (state_nxt != FULL);
      valid_q <= (state_nxt != EMPTY);
    end
  end

endmodule

// File: rtl/axi_header_slave.sv
// Header beat slave: masks non-kept bytes, derives byte length, counts beats.
// Latency 1 cycle through a two-entry skid buffer; s_ready registered, low only when FULL.
// Define AXI_HEADER_SLAVE_CHECK_EN to add the sticky keep/count mismatch checker.
module axi_header_slave
  import axi_header_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [DATA_BYTE_WIDTH-1:0] s_keep,
  input  logic [BYTE_CNT_WIDTH-1:0] s_byte_insert_cnt,
  output logic                      s_ready,
  output logic                      m_valid,
  output logic [DATA_WIDTH-1:0]     m_hdr,
  output logic [BYTE_CNT_WIDTH:0]   m_len,
  input  logic                      m_ready,
  output logic [15:0]               beat_cnt,
  output logic                      err_keep,
  output logic [7:0]                err_cnt
);

  localparam int LEN_W = BYTE_CNT_WIDTH + 1;
  localparam int PAY_W = DATA_WIDTH + LEN_W;

  logic [DATA_WIDTH-1:0] hdr_masked;
  logic [LEN_W-1:0]      len_in;
  logic [PAY_W-1:0]      pay_out;
  logic                  accept;

  always_comb begin
    hdr_masked = '0;
    for (int i = 0; i < DATA_BYTE_WIDTH; i++) begin
      hdr_masked[8*i +: 8] = s_keep[i] ? s_data[8*i +: 8] : 8'h00;
    end
  end

  // One extra bit so the all-ones count reports the full beat instead of wrapping.
  assign len_in = LEN_W'(s_byte_insert_cnt) + LEN_W'(1);

  axi_skid_buffer #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  ({len_in, hdr_masked}),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (pay_out),
    .m_ready (m_ready)
  );

  assign {m_len, m_hdr} = pay_out;
  assign accept         = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n)      beat_cnt <= 16'h0000;
    else if (accept) beat_cnt <= beat_cnt + 16'h0001;
  end

`ifdef AXI_HEADER_SLAVE_CHECK_EN
  logic [MAX_KEEP_BYTES-1:0] keep_exp;
  logic                      keep_bad;

  assign keep_exp = keep_from_cnt(int'(s_byte_insert_cnt));
  assign keep_bad = (keep_exp != MAX_KEEP_BYTES'(s_keep));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_keep <= 1'b0;
      err_cnt  <= 8'h00;
    end else if (accept && keep_bad) begin
      err_keep <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  assign err_keep = 1'b0;
  assign err_cnt  = 8'h00;
`endif

endmodule

// File: doc/axi_header_slave.md
AXI_HEADER_SLAVE -- requirements
Module: axi_header_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, header beat width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WIDTH, default DATA_WIDTH/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WIDTH, default $clog2(DATA_BYTE_WIDTH), width of the byte-count field.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  header beat valid.
REQ-007 SHALL have port s_data  input  DATA_WIDTH  header beat data; byte 0 in bits [7:0].
REQ-008 SHALL have port s_keep  input  DATA_BYTE_WIDTH  byte enables; valid bytes are low-justified.
REQ-009 SHALL have port s_byte_insert_cnt  input  BYTE_CNT_WIDTH  number of valid bytes minus one.
REQ-010 SHALL have port s_ready  output  1  beat accept, registered.
REQ-011 SHALL have port m_valid  output  1  extracted header valid.
REQ-012 SHALL have port m_hdr  output  DATA_WIDTH  s_data with non-kept bytes forced to 0.
REQ-013 SHALL have port m_len  output  BYTE_CNT_WIDTH+1  valid byte count, 1..DATA_BYTE_WIDTH.
REQ-014 SHALL have port m_ready  input  1  downstream accept.
REQ-015 SHALL have port beat_cnt  output  16  accepted input beats, wraps modulo 2^16.
REQ-016 SHALL have port err_keep  output  1  sticky keep/count mismatch flag.
REQ-017 SHALL have port err_cnt  output  8  mismatch count, saturating at 255.

Function
REQ-018 SHALL accept an input beat on any rising edge where s_valid && s_ready, and produce an output transfer on any edge where m_valid && m_ready.
REQ-019 SHALL drive m_valid, m_hdr and m_len from registers, never combinationally from s_*.
REQ-020 SHALL present an accepted beat on m_* the cycle after acceptance when the output register is empty or being drained; latency is 1 cycle.
REQ-021 SHALL sustain 1 beat/cycle with m_ready held high.
REQ-022 SHALL buffer exactly two beats (output register plus skid) using states EMPTY, ONE and FULL.
REQ-023 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; FULL->ONE on drain; stay in ONE on simultaneous accept and drain.
REQ-024 SHALL register s_ready as the condition "next state != FULL"; it drops the cycle after FULL is entered.
REQ-025 SHALL hold m_* stable while m_valid && !m_ready, and SHALL preserve input beat order.
REQ-026 SHALL compute m_len = s_byte_insert_cnt + 1 zero-extended to BYTE_CNT_WIDTH+1; it SHALL NOT wrap at the all-ones count.
REQ-027 SHALL zero byte i of m_hdr when s_keep[i] == 0.
REQ-028 SHALL increment beat_cnt by 1 per accepted beat, wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL treat s_data, s_keep and s_byte_insert_cnt as don't-care when s_valid is 0.

Reset
REQ-030 SHALL, while rst_n is low at a clock edge, set the state to EMPTY, s_ready=0, m_valid=0, m_hdr=0, m_len=0, beat_cnt=0, err_keep=0 and err_cnt=0.
REQ-031 SHALL set s_ready=1 on the first edge with rst_n high.
REQ-032 SHALL discard buffered beats when reset is asserted mid-stream, with no output transfer for them afterward.

Configuration
REQ-033 SHALL, with macro AXI_HEADER_SLAVE_CHECK_EN defined, check each accepted beat: s_keep must equal (1 << (s_byte_insert_cnt+1)) - 1.
REQ-034 SHALL, on a mismatch, set err_keep the cycle after acceptance (sticky until reset) and increment err_cnt, saturating at 255; the beat still passes through per REQ-026/027.
REQ-035 SHALL, without AXI_HEADER_SLAVE_CHECK_EN, tie err_keep and err_cnt to 0 and contain no check logic.

Structure
REQ-036 SHALL take the state enum (EMPTY/ONE/FULL) and a keep-mask-from-count function from shared package axi_header_pkg.
REQ-037 SHALL implement the two-entry buffer as sub-module axi_skid_buffer, parameterised by payload width; the check logic and counters reside in the top level.

Verification
REQ-038 Reset release, then s_valid=1, s_data=0xDEADBEEF, keep=4'b1111, cnt=3, m_ready=1 -> next cycle m_valid=1, m_hdr=0xDEADBEEF, m_len=4, beat_cnt=1.
REQ-039 Beat with keep=4'b0011, cnt=1, data=0xDEADBEF0 -> m_hdr=0x0000BEF0, m_len=2.
REQ-040 m_ready=0 with continuous s_valid -> two beats accepted, then s_ready=0; m_hdr stays equal to the first beat; on m_ready=1 both beats emerge in order with no loss.
REQ-041 With AXI_HEADER_SLAVE_CHECK_EN defined: keep=4'b0111, cnt=0 -> err_keep=1 and err_cnt=1; 300 such beats -> err_cnt=255.
REQ-042 65536 accepted beats -> beat_cnt=0; rst_n low for one cycle in state FULL -> m_valid=0, s_ready=0, then s_ready=1.
